lsu_ctrl: RTL

//   Multi-cycle load/store unit for the MEM stage. Accepts one access per handshake and checks alignment.

---
 rtl/lsu_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store unit: one access per handshake, alignment check, word bus with byte enables.
// Latency: misaligned 1 edge after accept, aligned >=2 edges after accept; no backpressure beyond req_ready (IDLE only). Optional LSU_TIMEOUT_EN.
module lsu_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        ld_sel,
    input  logic [1:0]        st_sel,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              exc,
    output logic [4:0]        exc_code,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_err
);

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LBU = 3'b001;
    localparam logic [2:0] LD_LB  = 3'b010;
    localparam logic [2:0] LD_LHU = 3'b011;
    localparam logic [2:0] LD_LH  = 3'b100;

    localparam logic [1:0] ST_SB = 2'b01;
    localparam logic [1:0] ST_SH = 2'b10;
    localparam logic [1:0] ST_SW = 2'b11;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        ld_q, ld_d;
    logic [1:0]        st_q, st_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              exc_q, exc_d;
    logic [4:0]        exc_code_q, exc_code_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    logic [2:0] ld_norm;
    logic       is_store;
    logic       misaligned;

    function automatic logic [31:0] load_ext(input logic [2:0] sel, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sel)
            LD_LBU:  load_ext = {24'h0, b};
            LD_LB:   load_ext = {{24{b[7]}}, b};
            LD_LHU:  load_ext = {16'h0, h};
            LD_LH:   load_ext = {{16{h[15]}}, h};
            default: load_ext = w;
        endcase
    endfunction

    // Undefined load selects behave as lw, including for the alignment check.
    always_comb begin
        ld_norm  = (ld_sel > LD_LH) ? LD_LW : ld_sel;
        is_store = (st_sel != 2'b00);
        if (is_store)
            misaligned = (st_sel == ST_SW) ? (addr[1:0] != 2'b00) :
                         (st_sel == ST_SH) ? addr[0] : 1'b0;
        else
            misaligned = (ld_norm == LD_LW) ? (addr[1:0] != 2'b00) :
                         ((ld_norm == LD_LH) || (ld_norm == LD_LHU)) ? addr[0] : 1'b0;
    end

    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        ld_d         = ld_q;
        st_d         = st_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        resp_valid_d = 1'b0;
        rdata_d      = '0;
        exc_d        = 1'b0;
        exc_code_d   = '0;
`ifdef LSU_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_lo_d = addr[1:0];
                    ld_d      = ld_norm;
                    st_d      = st_sel;
                    if (misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        exc_d        = 1'b1;
                        exc_code_d   = is_store ? EXC_ADES : EXC_ADEL;
                    end else begin
                        state_d    = S_WAIT;
                        bus_req_d  = 1'b1;
                        bus_we_d   = is_store;
                        bus_addr_d = {addr[ADDR_W-1:2], 2'b00};
`ifdef LSU_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                        case (st_sel)
                            ST_SB: begin
                                bus_be_d    = 4'b0001 << addr[1:0];
                                bus_wdata_d = {4{wdata[7:0]}};
                            end
                            ST_SH: begin
                                bus_be_d    = addr[1] ? 4'b1100 : 4'b0011;
                                bus_wdata_d = {2{wdata[15:0]}};
                            end
                            ST_SW: begin
                                bus_be_d    = 4'b1111;
                                bus_wdata_d = wdata;
                            end
                            default: begin
                                bus_be_d    = 4'b1111;
                                bus_wdata_d = '0;
                            end
                        endcase
                    end
                end
            end
            S_WAIT: begin
                if (bus_err) begin
                    state_d      = S_RESP;
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    exc_d        = 1'b1;
                    exc_code_d   = EXC_DBE;
                end else if (bus_ack) begin
                    state_d      = S_RESP;
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    rdata_d      = (st_q != 2'b00) ? 32'h0 : load_ext(ld_q, addr_lo_q, bus_rdata);
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = S_RESP;
                    bus_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    exc_d        = 1'b1;
                    exc_code_d   = EXC_DBE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_lo_q    <= '0;
            ld_q         <= '0;
            st_q         <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            exc_q        <= 1'b0;
            exc_code_q   <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            ld_q         <= ld_d;
            st_q         <= st_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            exc_q        <= exc_d;
            exc_code_q   <= exc_code_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign exc        = exc_q;
    assign exc_code   = exc_code_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule
